// File: rtl/prot_eng_rx.sv
// UDP receive engine: checks Eth/IPv4/UDP header fields, strips the 11 header lines and forwards the payload.
// Latency: payload path is combinational (zero cycles); the header takes one line per cycle.
// Backpressure: dst_rdy_i only stalls the payload phase; optional IP checksum check under PROT_ENG_RX_IPCSUM_EN.
module prot_eng_rx #(
   parameter int BASE = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [35:0] datain,
   input  logic        src_rdy_i,
   output logic        dst_rdy_o,
   output logic [35:0] dataout,
   output logic        src_rdy_o,
   input  logic        dst_rdy_i,
   output logic [31:0] status
);
   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

   localparam logic [7:0] ADDR_PORT  = 8'(BASE);
   localparam logic [7:0] ADDR_ETYPE = 8'(BASE + 1);

   state_t      state;
   logic [3:0]  line_cnt;
   logic        bad;
   logic        first;
   logic [15:0] pass_count;
   logic [15:0] drop_count;
   logic [16:0] port_reg;
   logic [15:0] etype_reg;
   logic        sof;
   logic        eof;
   logic        xfer;
   logic        hdr_bad;
   logic        csum_bad;
   logic        unused_set_data;

   assign sof             = datain[32];
   assign eof             = datain[33];
   assign dst_rdy_o       = (state == PAYLOAD) ? dst_rdy_i : 1'b1;
   assign src_rdy_o       = src_rdy_i & (state == PAYLOAD);
   assign xfer            = src_rdy_i & dst_rdy_o;
   assign dataout         = {datain[35:33], first, datain[31:0]};
   assign status          = {drop_count, pass_count};
   assign unused_set_data = ^set_data[31:17];

`ifdef PROT_ENG_RX_IPCSUM_EN
   logic [15:0] csum;
   logic [15:0] csum_nxt;

   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   assign csum_nxt = oc_add(oc_add(csum, datain[31:16]), datain[15:0]);
   assign csum_bad = (line_cnt == 4'd8) && (csum_nxt != 16'hFFFF);

   // Running ones-complement sum over IP header lines 4-8; restarts on every SOF.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         csum <= '0;
      end else if (xfer) begin
         if (sof)
            csum <= '0;
         else if (state == HDR && line_cnt >= 4'd4 && line_cnt <= 4'd8)
            csum <= csum_nxt;
      end
   end
`else
   assign csum_bad = 1'b0;
`endif

   assign hdr_bad = !port_reg[16]
                  || (line_cnt == 4'd3 && datain[15:0] != etype_reg)
                  || (line_cnt == 4'd6 && datain[23:16] != 8'd17)
                  || (line_cnt == 4'd9 && datain[15:0] != port_reg[15:0])
                  || csum_bad;

   // Settings survive clear; only reset returns them to defaults.
   always_ff @(posedge clk) begin
      if (reset) begin
         port_reg  <= '0;
         etype_reg <= 16'h0800;
      end else if (set_stb) begin
         if (set_addr == ADDR_PORT)
            port_reg <= set_data[16:0];
         if (set_addr == ADDR_ETYPE)
            etype_reg <= set_data[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state      <= IDLE;
         line_cnt   <= '0;
         bad        <= 1'b0;
         first      <= 1'b0;
         pass_count <= '0;
         drop_count <= '0;
      end else if (xfer) begin
         case (state)
            IDLE: begin
               if (sof) begin
                  if (eof) begin
                     drop_count <= drop_count + 16'd1;
                  end else begin
                     state    <= HDR;
                     line_cnt <= 4'd1;
                     bad      <= 1'b0;
                  end
               end
            end
            HDR: begin
               // A SOF here aborts the current frame; a SOF+EOF line is also a runt of its own.
               if (sof) begin
                  line_cnt <= 4'd1;
                  bad      <= 1'b0;
                  if (eof) begin
                     drop_count <= drop_count + 16'd2;
                     state      <= IDLE;
                  end else begin
                     drop_count <= drop_count + 16'd1;
                  end
               end else if (eof) begin
                  drop_count <= drop_count + 16'd1;
                  state      <= IDLE;
               end else begin
                  line_cnt <= line_cnt + 4'd1;
                  bad      <= bad | hdr_bad;
                  if (line_cnt == 4'd10) begin
                     if (bad | hdr_bad) begin
                        state <= DROP;
                     end else begin
                        state <= PAYLOAD;
                        first <= 1'b1;
                     end
                  end
               end
            end
            PAYLOAD: begin
               first <= 1'b0;
               if (eof) begin
                  pass_count <= pass_count + 16'd1;
                  state      <= IDLE;
               end
            end
            DROP: begin
               if (eof) begin
                  drop_count <= drop_count + 16'd1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_prot_eng_rx.sv
// Directed bench for prot_eng_rx: builds Eth/IPv4/UDP frames and checks forwarded payload and status counters.
`timescale 1ns/1ps
module tb_prot_eng_rx;
   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [35:0] datain;
   logic        src_rdy_i;
   logic        dst_rdy_o;
   logic [35:0] dataout;
   logic        src_rdy_o;
   logic        dst_rdy_i;
   logic [31:0] status;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int vld_cycles = 0;
   int rdy_low_nonpay = 0;
   int mirror_bad = 0;
   logic toggle_en = 1'b0;
   logic [35:0] frm[$];
   logic [35:0] outq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prot_eng_rx #(.BASE(0)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .datain(datain), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
      .dataout(dataout), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
      .status(status)
   );

   always @(negedge clk) begin
      if (src_rdy_o) vld_cycles++;
      if (src_rdy_o && dst_rdy_i) outq.push_back(dataout);
      if (src_rdy_o && (dst_rdy_o !== dst_rdy_i)) mirror_bad++;
      if (src_rdy_i && !src_rdy_o && (dst_rdy_o !== 1'b1)) rdy_low_nonpay++;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle_en) dst_rdy_i = ~dst_rdy_i;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   task automatic build_frame(input int n, input logic [15:0] etype, input logic [7:0] proto,
                              input logic [15:0] dport, input bit bad_csum);
      logic [31:0] w[32];
      logic [15:0] sum;
      for (int i = 0; i < 32; i++) begin
         w[i] = 32'hC0DE_0000 + 32'(i);
      end
      w[3]  = {16'h0000, etype};
      w[4]  = 32'h4500_0030;
      w[5]  = 32'h1234_4000;
      w[6]  = {8'h40, proto, 16'h0000};
      w[7]  = 32'h0A00_0001;
      w[8]  = 32'h0A00_0002;
      w[9]  = {16'h5555, dport};
      w[10] = 32'h0018_0000;
      sum = 16'h0000;
      for (int i = 4; i <= 8; i++) begin
         sum = oc_add(oc_add(sum, w[i][31:16]), w[i][15:0]);
      end
      w[6][15:0] = ~sum ^ (bad_csum ? 16'h0001 : 16'h0000);
      frm.delete();
      for (int i = 0; i < n; i++) begin
         frm.push_back({(i == n - 1) ? 2'b10 : 2'b00, i == n - 1, i == 0, w[i]});
      end
   endtask

   task automatic drive(input logic [35:0] d);
      int n;
      n = 0;
      datain    = d;
      src_rdy_i = 1'b1;
      @(negedge clk);
      while (dst_rdy_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: dst_rdy_o=%b stayed low for %0d cycles, required 1", dst_rdy_o, n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) drive(frm[i]);
      src_rdy_i = 1'b0;
      datain    = '0;
   endtask

   task automatic send_frame();
      send_range(0, frm.size() - 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
      set_stb  = 1'b1;
      set_addr = a;
      set_data = d;
      @(posedge clk);
      #1;
      set_stb  = 1'b0;
   endtask

   task automatic clear_dut();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      outq.delete();
      vld_cycles     = 0;
      rdy_low_nonpay = 0;
      mirror_bad     = 0;
   endtask

   task automatic check_payload(input string name, input int base_idx, input int src_first, input int cnt);
      logic [35:0] got;
      logic [35:0] exp;
      for (int k = 0; k < cnt; k++) begin
         got = (base_idx + k < outq.size()) ? outq[base_idx + k] : 36'hx;
         exp = {frm[src_first + k][35:33], k == 0, frm[src_first + k][31:0]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s_line%0d: got %h expected %h", name, k, got, exp);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
      datain = '0; src_rdy_i = 1'b1; dst_rdy_i = 1'b1;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (src_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_src_rdy_o: got %b expected 0", src_rdy_o); end
      checks++;
      if (dst_rdy_o !== 1'b1) begin errors++; $display("FAIL reset_dst_rdy_o: got %b expected 1", dst_rdy_o); end
      checks++;
      if (status !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 00000000", status); end
      @(posedge clk);
      #1;
      src_rdy_i = 1'b0;
   endtask

   task automatic test_match();
      clear_dut();
      write_reg(8'd0, 32'h0001_1234);
      build_frame(16, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_frame();
      idle(3);
      checks++;
      if (outq.size() != 5) begin errors++; $display("FAIL match_count: got %0d expected 5", outq.size()); end
      check_payload("match", 0, 11, 5);
      checks++;
      if (status !== 32'h0000_0001) begin errors++; $display("FAIL match_status: got %h expected 00000001", status); end
   endtask

   task automatic test_port_mismatch();
      clear_dut();
      build_frame(16, 16'h0800, 8'd17, 16'h1235, 1'b0);
      send_frame();
      idle(3);
      checks++;
      if (vld_cycles != 0) begin errors++; $display("FAIL mismatch_vld: got %0d valid cycles expected 0", vld_cycles); end
      checks++;
      if (status !== 32'h0001_0000) begin errors++; $display("FAIL mismatch_status: got %h expected 00010000", status); end
      checks++;
      if (rdy_low_nonpay != 0) begin errors++; $display("FAIL mismatch_dst_rdy: got %0d low cycles expected 0", rdy_low_nonpay); end
   endtask

   task automatic test_runts();
      clear_dut();
      build_frame(8, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_frame();
      idle(2);
      checks++;
      if (status !== 32'h0001_0000) begin errors++; $display("FAIL runt8_status: got %h expected 00010000", status); end
      checks++;
      if (dst_rdy_o !== 1'b1) begin errors++; $display("FAIL runt8_dst_rdy: got %b expected 1", dst_rdy_o); end
      build_frame(11, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_frame();
      idle(2);
      checks++;
      if (status !== 32'h0002_0000) begin errors++; $display("FAIL runt11_status: got %h expected 00020000", status); end
      checks++;
      if (vld_cycles != 0) begin errors++; $display("FAIL runt_vld: got %0d valid cycles expected 0", vld_cycles); end
   endtask

   task automatic test_field_mismatch();
      clear_dut();
      build_frame(16, 16'h0800, 8'd6, 16'h1234, 1'b0);
      send_frame();
      idle(2);
      checks++;
      if (status !== 32'h0001_0000) begin errors++; $display("FAIL proto_status: got %h expected 00010000", status); end
      write_reg(8'd0, 32'h0000_1234);
      build_frame(16, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_frame();
      idle(2);
      checks++;
      if (status !== 32'h0002_0000) begin errors++; $display("FAIL disable_status: got %h expected 00020000", status); end
      write_reg(8'd0, 32'h0001_1234);
      write_reg(8'd1, 32'h0000_86DD);
      send_frame();
      idle(2);
      checks++;
      if (status !== 32'h0003_0000) begin errors++; $display("FAIL etype_status: got %h expected 00030000", status); end
      build_frame(16, 16'h86DD, 8'd17, 16'h1234, 1'b0);
      send_frame();
      idle(2);
      checks++;
      if (status !== 32'h0003_0001) begin errors++; $display("FAIL etype_prog_status: got %h expected 00030001", status); end
      write_reg(8'd1, 32'h0000_0800);
   endtask

   task automatic test_back_to_back();
      clear_dut();
      build_frame(16, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_frame();
      build_frame(14, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_frame();
      idle(3);
      checks++;
      if (outq.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", outq.size()); end
      check_payload("b2b_second", 5, 11, 3);
      checks++;
      if (status !== 32'h0000_0002) begin errors++; $display("FAIL b2b_status: got %h expected 00000002", status); end
   endtask

   task automatic test_backpressure();
      int t0;
      int t1;
      clear_dut();
      build_frame(16, 16'h0800, 8'd17, 16'h1234, 1'b0);
      dst_rdy_i = 1'b0;
      t0 = cyc;
      send_range(0, 10);
      t1 = cyc;
      checks++;
      if (t1 - t0 != 11) begin errors++; $display("FAIL bp_header_cycles: got %0d expected 11", t1 - t0); end
      toggle_en = 1'b1;
      send_range(11, 15);
      toggle_en = 1'b0;
      dst_rdy_i = 1'b1;
      idle(3);
      checks++;
      if (outq.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", outq.size()); end
      check_payload("bp", 0, 11, 5);
      checks++;
      if (mirror_bad != 0) begin errors++; $display("FAIL bp_mirror: got %0d mismatched cycles expected 0", mirror_bad); end
      checks++;
      if (rdy_low_nonpay != 0) begin errors++; $display("FAIL bp_hdr_rdy: got %0d low cycles expected 0", rdy_low_nonpay); end
      checks++;
      if (status !== 32'h0000_0001) begin errors++; $display("FAIL bp_status: got %h expected 00000001", status); end
   endtask

   task automatic test_reset_midframe();
      clear_dut();
      build_frame(16, 16'h0800, 8'd17, 16'h1234, 1'b0);
      send_range(0, 12);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      checks++;
      if (status !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h expected 00000000", status); end
      outq.delete();
      vld_cycles = 0;
      send_range(13, 15);
      idle(2);
      checks++;
      if (vld_cycles != 0 || status !== 32'h0) begin
         errors++;
         $display("FAIL midreset_leftover: got %0d valid cycles status %h expected 0 and 00000000", vld_cycles, status);
      end
      write_reg(8'd0, 32'h0001_1234);
      send_frame();
      idle(3);
      checks++;
      if (outq.size() != 5) begin errors++; $display("FAIL midreset_count: got %0d expected 5", outq.size()); end
      checks++;
      if (status !== 32'h0000_0001) begin errors++; $display("FAIL midreset_status2: got %h expected 00000001", status); end
   endtask

   task automatic test_ipcsum();
      logic [31:0] exp;
`ifdef PROT_ENG_RX_IPCSUM_EN
      exp = 32'h0001_0000;
`else
      exp = 32'h0000_0001;
`endif
      clear_dut();
      build_frame(16, 16'h0800, 8'd17, 16'h1234, 1'b1);
      send_frame();
      idle(3);
      checks++;
      if (status !== exp) begin errors++; $display("FAIL ipcsum_status: got %h expected %h", status, exp); end
   endtask

   initial begin
      test_reset();
      test_match();
      test_port_mismatch();
      test_runts();
      test_field_mismatch();
      test_back_to_back();
      test_backpressure();
      test_reset_midframe();
      test_ipcsum();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
